// File: rtl/asmd_pkg.sv
// Shared state encoding and default sizing for the multiplier-sharing arbiter.
package asmd_pkg;
    localparam int WORD_LENGTH_DEFAULT = 8;
    localparam int NUM_REQ_DEFAULT     = 4;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } state_t;
endpackage

// File: rtl/asmd_mult_arbiter_rr_arbiter.sv
// Combinational round-robin select: first active request at or after ptr, wrapping modulo num_req.
module rr_arbiter
    import asmd_pkg::*;
#(
    parameter int num_req = NUM_REQ_DEFAULT,
    parameter int idx_w   = $clog2(num_req)
) (
    input  logic [num_req-1:0] req,
    input  logic [idx_w-1:0]   ptr,
    output logic [num_req-1:0] grant,
    output logic [idx_w-1:0]   idx
);
    localparam logic [idx_w:0] NUM_REQ_W = (idx_w + 1)'(num_req);

    logic [idx_w:0] cand;
    logic           found;

    // One extra bit on cand so ptr+k cannot overflow before the modulo fold.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < num_req; k++) begin
            cand = {1'b0, ptr} + (idx_w + 1)'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!found && req[cand[idx_w-1:0]]) begin
                found                  = 1'b1;
                idx                    = cand[idx_w-1:0];
                grant[cand[idx_w-1:0]] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/asmd_mult_arbiter.sv
// Shares one external multiplier among num_req requesters, one job in flight at a time,
// granting round-robin and routing the product back to the job's owner.
module asmd_mult_arbiter
    import asmd_pkg::*;
#(
    parameter int word_length = WORD_LENGTH_DEFAULT,
    parameter int num_req     = NUM_REQ_DEFAULT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [num_req-1:0]             req_valid,
    input  logic [num_req*word_length-1:0] req_word0,
    input  logic [num_req*word_length-1:0] req_word1,
    output logic [num_req-1:0]             req_grant,
    output logic [num_req-1:0]             rsp_valid,
    output logic [2*word_length-1:0]       rsp_product,
    output logic                           mul_start,
    output logic [word_length-1:0]         mul_word0,
    output logic [word_length-1:0]         mul_word1,
    input  logic [2*word_length-1:0]       mul_product,
    input  logic                           mul_ready
);
    localparam int               IDX_W    = $clog2(num_req);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(num_req - 1);

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         ptr_q, ptr_d;
    logic [IDX_W-1:0]         owner_q, owner_d;
    logic [word_length-1:0]   mul_word0_q, mul_word0_d;
    logic [word_length-1:0]   mul_word1_q, mul_word1_d;
    logic [2*word_length-1:0] rsp_product_q, rsp_product_d;
    logic                     ready_seen_q, ready_seen_d;

    logic [num_req-1:0]       arb_grant;
    logic [IDX_W-1:0]         arb_idx;

    rr_arbiter #(
        .num_req (num_req),
        .idx_w   (IDX_W)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // Grant is gated by reset so no requester sees an acceptance while the block is held in reset.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        owner_d       = owner_q;
        mul_word0_d   = mul_word0_q;
        mul_word1_d   = mul_word1_q;
        rsp_product_d = rsp_product_q;
        ready_seen_d  = ready_seen_q;
        req_grant     = '0;
        rsp_valid     = '0;
        mul_start     = 1'b0;

        case (state_q)
            IDLE: begin
                if (reset && mul_ready && (|req_valid)) begin
                    req_grant   = arb_grant;
                    mul_word0_d = req_word0[int'(arb_idx)*word_length +: word_length];
                    mul_word1_d = req_word1[int'(arb_idx)*word_length +: word_length];
                    owner_d     = arb_idx;
                    state_d     = LAUNCH;
                end
            end
            LAUNCH: begin
                mul_start    = 1'b1;
                ready_seen_d = 1'b0;
                state_d      = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A multiplier that never drops ready is taken as done after two high cycles.
                if (!mul_ready) begin
                    state_d = WAIT_DONE;
                end else if (ready_seen_q) begin
                    rsp_product_d = mul_product;
                    state_d       = RESP;
                end else begin
                    ready_seen_d = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (mul_ready) begin
                    rsp_product_d = mul_product;
                    state_d       = RESP;
                end
            end
            RESP: begin
                rsp_valid[owner_q] = 1'b1;
                ptr_d              = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
                state_d            = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            owner_q       <= '0;
            mul_word0_q   <= '0;
            mul_word1_q   <= '0;
            rsp_product_q <= '0;
            ready_seen_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            mul_word0_q   <= mul_word0_d;
            mul_word1_q   <= mul_word1_d;
            rsp_product_q <= rsp_product_d;
            ready_seen_q  <= ready_seen_d;
        end
    end

    assign mul_word0   = mul_word0_q;
    assign mul_word1   = mul_word1_q;
    assign rsp_product = rsp_product_q;
endmodule

// File: tb/tb_asmd_mult_arbiter.sv
// Directed bench for asmd_mult_arbiter with a behavioural multiplier of configurable latency.
module tb_asmd_mult_arbiter;
    import asmd_pkg::*;

    localparam int W = 8;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_word0;
    logic [N*W-1:0]   req_word1;
    logic [N-1:0]     req_grant;
    logic [N-1:0]     rsp_valid;
    logic [2*W-1:0]   rsp_product;
    logic             mul_start;
    logic [W-1:0]     mul_word0;
    logic [W-1:0]     mul_word1;
    logic [2*W-1:0]   mul_product;
    logic             mul_ready;

    int vectors     = 0;
    int miscompares = 0;
    int mulLatency  = 3;
    bit forceBusy   = 1'b0;
    int busyLeft    = 0;

    asmd_mult_arbiter #(
        .word_length (W),
        .num_req     (N)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_word0   (req_word0),
        .req_word1   (req_word1),
        .req_grant   (req_grant),
        .rsp_valid   (rsp_valid),
        .rsp_product (rsp_product),
        .mul_start   (mul_start),
        .mul_word0   (mul_word0),
        .mul_word1   (mul_word1),
        .mul_product (mul_product),
        .mul_ready   (mul_ready)
    );

    always #5 clk = ~clk;

    // Multiplier model: drops ready for mulLatency cycles after a start, shows junk while busy.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_ready   <= 1'b1;
            mul_product <= '0;
            busyLeft    <= 0;
        end else if (mul_start) begin
            if (mulLatency == 0) begin
                mul_product <= 16'(mul_word0) * 16'(mul_word1);
                mul_ready   <= !forceBusy;
            end else begin
                mul_product <= 16'hDEAD;
                mul_ready   <= 1'b0;
                busyLeft    <= mulLatency;
            end
        end else if (busyLeft > 1) begin
            busyLeft <= busyLeft - 1;
        end else if (busyLeft == 1) begin
            busyLeft    <= 0;
            mul_product <= 16'(mul_word0) * 16'(mul_word1);
            mul_ready   <= 1'b1;
        end else begin
            mul_ready <= !forceBusy;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] req, input logic [N*W-1:0] w0, input logic [N*W-1:0] w1);
        req_valid = req;
        req_word0 = w0;
        req_word1 = w1;
    endtask

    task automatic doReset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus('0, '0, '0);
        repeat (2) @(negedge clk);
        checkOutput({tag, " outputs"},
                    {req_grant, rsp_valid, rsp_product, mul_start, mul_word0, mul_word1}, 64'd0);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // One job: wait for the grant, apply post-grant inputs, then follow it to the response.
    task automatic runJob(input string tag, input logic [N-1:0] expGrant, input logic [2*W-1:0] expProduct,
                          input logic [W-1:0] expW0, input logic [W-1:0] expW1,
                          input logic [N-1:0] reqAfter, input logic [N*W-1:0] w0After,
                          input logic [N*W-1:0] w1After);
        int n = 0;
        int extraStarts = 0;
        #1;
        while (req_grant == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " grant"}, req_grant, expGrant);
        @(posedge clk);
        #1;
        applyStimulus(reqAfter, w0After, w1After);
        @(negedge clk);
        checkOutput({tag, " start"}, {mul_start, mul_word0, mul_word1}, {1'b1, expW0, expW1});
        n = 0;
        @(negedge clk);
        while (rsp_valid == '0 && n < 40) begin
            if (mul_start) extraStarts++;
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " extra starts"}, extraStarts, 0);
        checkOutput({tag, " rsp_valid"}, rsp_valid, expGrant);
        checkOutput({tag, " product"}, rsp_product, expProduct);
        checkOutput({tag, " held operands"}, {mul_word0, mul_word1}, {expW0, expW1});
        @(negedge clk);
        checkOutput({tag, " rsp pulse"}, rsp_valid, 0);
    endtask

    initial begin
        logic [N-1:0] seenMask;
        reset = 1'b0;
        applyStimulus('0, '0, '0);

        doReset("reset");

        applyStimulus(4'b0001, {24'd0, 8'd3}, {24'd0, 8'd5});
        runJob("3x5", 4'b0001, 16'd15, 8'd3, 8'd5, 4'b0000, req_word0, req_word1);

        doReset("reset2");
        applyStimulus(4'b1111, {8'd5, 8'd4, 8'd3, 8'd2}, {8'd13, 8'd12, 8'd11, 8'd10});
        runJob("rr0", 4'b0001, 16'd20, 8'd2, 8'd10, 4'b1111, req_word0, req_word1);
        runJob("rr1", 4'b0010, 16'd33, 8'd3, 8'd11, 4'b1111, req_word0, req_word1);
        runJob("rr2", 4'b0100, 16'd48, 8'd4, 8'd12, 4'b1111, req_word0, req_word1);
        runJob("rr3", 4'b1000, 16'd65, 8'd5, 8'd13, 4'b0000, req_word0, req_word1);

        applyStimulus(4'b0001, {8'd12, 8'd0, 8'd0, 8'hFF}, {8'd13, 8'd0, 8'hA5, 8'hFF});
        runJob("ffxff", 4'b0001, 16'hFE01, 8'hFF, 8'hFF, 4'b0000, req_word0, req_word1);
        mulLatency = 0;
        applyStimulus(4'b0010, req_word0, req_word1);
        runJob("0xa5", 4'b0010, 16'd0, 8'd0, 8'hA5, 4'b0000, req_word0, req_word1);
        applyStimulus(4'b1000, req_word0, req_word1);
        runJob("nobusy", 4'b1000, 16'd156, 8'd12, 8'd13, 4'b0000, req_word0, req_word1);
        mulLatency = 3;

        doReset("reset3");
        forceBusy = 1'b1;
        repeat (2) @(negedge clk);
        applyStimulus(4'b0010, {16'd0, 8'd6, 8'd0}, {16'd0, 8'd7, 8'd0});
        seenMask = '0;
        repeat (6) begin
            @(negedge clk);
            seenMask = seenMask | req_grant;
        end
        checkOutput("busy no grant", seenMask, 0);
        forceBusy = 1'b0;
        runJob("after busy", 4'b0010, 16'd42, 8'd6, 8'd7, 4'b0000, req_word0, req_word1);

        applyStimulus(4'b0100, {8'd0, 8'd7, 16'd0}, {8'd0, 8'd9, 16'd0});
        runJob("latched", 4'b0100, 16'd63, 8'd7, 8'd9, 4'b0000, {8'd0, 8'hEE, 16'd0}, {8'd0, 8'h11, 16'd0});

        mulLatency = 5;
        applyStimulus(4'b0010, {16'd0, 8'd6, 8'd0}, {16'd0, 8'd7, 8'd0});
        #1;
        checkOutput("midjob grant", req_grant, 4'b0010);
        @(posedge clk);
        #1;
        applyStimulus(4'b0000, req_word0, req_word1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midjob reset outputs",
                    {req_grant, rsp_valid, rsp_product, mul_start, mul_word0, mul_word1}, 64'd0);
        reset = 1'b1;
        seenMask = '0;
        repeat (8) begin
            @(negedge clk);
            seenMask = seenMask | rsp_valid;
        end
        checkOutput("midjob no rsp", seenMask, 0);
        mulLatency = 3;
        applyStimulus(4'b1111, {8'd5, 8'd4, 8'd3, 8'd2}, {8'd13, 8'd12, 8'd11, 8'd10});
        runJob("restart", 4'b0001, 16'd20, 8'd2, 8'd10, 4'b0000, req_word0, req_word1);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, wanted completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
